// File: rtl/reorder_tag_arbiter.sv
// Reorder-queue tag arbiter: sequences queue reset/init, grants one requester per cycle,
// tracks tag ownership and per-requester credits. Optional: REORDER_ARB_FIXED_PRIORITY_EN.
module reorder_tag_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int DEPTH     = 64,
  parameter int TAG_WIDTH = $clog2(DEPTH-1)+1,
  parameter int MAX_OUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rq_rst,
  output logic                   rq_increment,
  input  logic [TAG_WIDTH-1:0]   rq_index_tag,
  input  logic                   rq_full,
  output logic                   issue_valid,
  output logic [TAG_WIDTH-1:0]   issue_tag,
  output logic [ID_WIDTH-1:0]    issue_id,
  input  logic                   issue_stall,
  input  logic                   retire_valid,
  input  logic [TAG_WIDTH-2:0]   retire_tag,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   ready
);

  localparam int IW   = TAG_WIDTH-1;
  localparam int CW   = $clog2(MAX_OUT)+1;
  localparam int CNTW = $clog2(DEPTH+2)+1;

  typedef enum logic [1:0] {RESET, INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                issue_valid_q, issue_valid_d;
  logic [TAG_WIDTH-1:0] issue_tag_q, issue_tag_d;
  logic [ID_WIDTH-1:0] issue_id_q, issue_id_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [CW-1:0]       credit_q [NUM_REQ];
  logic [CW-1:0]       credit_d [NUM_REQ];
  logic [ID_WIDTH-1:0] owner_q [DEPTH];

  logic [NUM_REQ-1:0]  eligible;
  logic                win_found;
  logic [ID_WIDTH-1:0] win_id;
  logic                adv, grant, retire_fire;
  logic [ID_WIDTH-1:0] rd_id;

  // Sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESET: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        if (cnt_q == CNTW'(DEPTH+1)) state_d = RUN;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      eligible[i] = req[i] && (credit_q[i] < CW'(MAX_OUT));
  end

`ifdef REORDER_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
      end
    end
  end
`else
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  hi_elig;

  // Round-robin as two passes: indices at/above the pointer first, then wrap to the lowest.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      hi_elig[i] = eligible[i] && (i >= 32'(ptr_q));
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && hi_elig[i]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign adv         = !issue_valid_q || !issue_stall;
  assign grant       = (state_q == RUN) && adv && !rq_full && win_found;
  assign retire_fire = (state_q == RUN) && retire_valid;
  // Owner table is write-first: a same-cycle allocate of the retiring index wins.
  assign rd_id       = (grant && (rq_index_tag[IW-1:0] == retire_tag)) ? win_id
                                                                       : owner_q[retire_tag];

  always_comb begin
    gnt_d         = gnt_q;
    issue_valid_d = issue_valid_q;
    issue_tag_d   = issue_tag_q;
    issue_id_d    = issue_id_q;
    if (adv) begin
      issue_valid_d = grant;
      gnt_d         = grant ? (NUM_REQ'(1) << win_id) : '0;
      if (grant) begin
        issue_tag_d = rq_index_tag;
        issue_id_d  = win_id;
      end
    end
    rsp_valid_d = retire_fire ? (NUM_REQ'(1) << rd_id) : '0;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic inc, dec;
      inc = grant && (win_id == ID_WIDTH'(i));
      dec = retire_fire && (rd_id == ID_WIDTH'(i)) && (credit_q[i] != '0);
      credit_d[i] = credit_q[i];
      if (inc && !dec)      credit_d[i] = credit_q[i] + 1'b1;
      else if (dec && !inc) credit_d[i] = credit_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RESET;
      cnt_q         <= '0;
      gnt_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_tag_q   <= '0;
      issue_id_q    <= '0;
      rsp_valid_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      issue_valid_q <= issue_valid_d;
      issue_tag_q   <= issue_tag_d;
      issue_id_q    <= issue_id_d;
      rsp_valid_q   <= rsp_valid_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= credit_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (grant) owner_q[rq_index_tag[IW-1:0]] <= win_id;
  end

  assign gnt          = gnt_q;
  assign issue_valid  = issue_valid_q;
  assign issue_tag    = issue_tag_q;
  assign issue_id     = issue_id_q;
  assign rsp_valid    = rsp_valid_q;
  assign rq_increment = grant;
  assign ready        = (state_q == RUN);
  assign rq_rst       = (state_q == RESET) || ((state_q == INIT) && (cnt_q == '0));

endmodule

// File: tb/tb_reorder_tag_arbiter.sv
// Directed bench for reorder_tag_arbiter with a simple incrementing-tag queue model.
module tb_reorder_tag_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       rq_rst, rq_increment;
  logic [6:0] q_tag;
  logic       rq_full = 1'b0;
  logic       issue_valid;
  logic [6:0] issue_tag;
  logic [1:0] issue_id;
  logic       issue_stall = 1'b0;
  logic       retire_valid = 1'b0;
  logic [5:0] retire_tag = '0;
  logic [3:0] rsp_valid;
  logic       ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Queue model: tag counter cleared by rq_rst, advanced by rq_increment.
  always @(posedge clk) begin
    if (rq_rst)            q_tag <= '0;
    else if (rq_increment) q_tag <= q_tag + 7'd1;
  end

  reorder_tag_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .DEPTH(64), .TAG_WIDTH(7), .MAX_OUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rq_rst(rq_rst),
    .rq_increment(rq_increment), .rq_index_tag(q_tag), .rq_full(rq_full),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_id(issue_id),
    .issue_stall(issue_stall), .retire_valid(retire_valid), .retire_tag(retire_tag),
    .rsp_valid(rsp_valid), .ready(ready)
  );

  task automatic test_reset();
    int n;
    logic saw_inc;
    rst_n = 1'b0; req = 4'b1111;
    repeat (3) @(negedge clk);
    total++; if ({gnt, issue_valid, issue_tag, issue_id, rsp_valid, ready, rq_rst, rq_increment} !== {4'b0, 1'b0, 7'd0, 2'd0, 4'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_vals got gnt=%b v=%b tag=%0d id=%0d rsp=%b rdy=%b rst=%b inc=%b exp 0,0,0,0,0,0,1,0", gnt, issue_valid, issue_tag, issue_id, rsp_valid, ready, rq_rst, rq_increment);
    end
    rst_n = 1'b1; n = 0; saw_inc = 1'b0;
    while (n < 200 && ready !== 1'b1) begin
      @(negedge clk); n++;
      if (n == 1) begin total++; if (rq_rst !== 1'b1) begin bad++; $display("FAIL rq_rst_init0 got=%b exp=1", rq_rst); end end
      if (n == 2) begin total++; if (rq_rst !== 1'b0) begin bad++; $display("FAIL rq_rst_init1 got=%b exp=0", rq_rst); end end
      if (ready !== 1'b1 && rq_increment !== 1'b0) saw_inc = 1'b1;
    end
    req = 4'b0000;
    total++; if (n != 67) begin bad++; $display("FAIL ready_latency got=%0d exp=67", n); end
    total++; if (saw_inc !== 1'b0) begin bad++; $display("FAIL inc_before_ready got=%b exp=0", saw_inc); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eid;
    req = 4'b1111;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
`ifdef REORDER_ARB_FIXED_PRIORITY_EN
      eid = 2'(k / 16);
`else
      eid = 2'(k % 4);
`endif
      total++; if (issue_valid !== 1'b1 || issue_id !== eid || gnt !== (4'b0001 << eid) || issue_tag !== 7'(k)) begin
        bad++; $display("FAIL rr_grant k=%0d got v=%b id=%0d gnt=%b tag=%0d exp v=1 id=%0d tag=%0d", k, issue_valid, issue_id, gnt, issue_tag, eid, k);
      end
    end
    @(negedge clk);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rr_credit_stop got=%b exp=0", issue_valid); end
    req = 4'b0000;
    for (int t = 0; t <= 64; t++) begin
      if (t < 64) begin retire_valid = 1'b1; retire_tag = 6'(t); end
      else retire_valid = 1'b0;
      @(negedge clk);
      if (t < 64) begin
`ifdef REORDER_ARB_FIXED_PRIORITY_EN
        eid = 2'(t / 16);
`else
        eid = 2'(t % 4);
`endif
        total++; if (rsp_valid !== (4'b0001 << eid)) begin bad++; $display("FAIL rr_rsp t=%0d got=%b exp=%b", t, rsp_valid, 4'b0001 << eid); end
      end
    end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rsp_idle got=%b exp=0000", rsp_valid); end
    req = 4'b1111;
    @(negedge clk);
    total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd64 || issue_id !== 2'd0) begin
      bad++; $display("FAIL tag_wrap got v=%b tag=%0d id=%0d exp v=1 tag=64 id=0", issue_valid, issue_tag, issue_id);
    end
    req = 4'b0000; retire_valid = 1'b1; retire_tag = 6'd0;
    @(negedge clk);
    retire_valid = 1'b0;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL wrap_rsp got=%b exp=0001", rsp_valid); end
  endtask

  task automatic test_credit_limit();
    req = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      total++; if (issue_valid !== 1'b1 || issue_id !== 2'd0 || issue_tag !== 7'(65 + k)) begin
        bad++; $display("FAIL limit_grant k=%0d got v=%b id=%0d tag=%0d exp v=1 id=0 tag=%0d", k, issue_valid, issue_id, issue_tag, 65 + k);
      end
    end
    repeat (3) begin
      @(negedge clk);
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL limit_hold got=%b exp=0", issue_valid); end
    end
    retire_valid = 1'b1; retire_tag = 6'd1;
    @(negedge clk);
    retire_valid = 1'b0;
    total++; if (rsp_valid !== 4'b0001 || issue_valid !== 1'b0) begin bad++; $display("FAIL limit_rsp got rsp=%b v=%b exp rsp=0001 v=0", rsp_valid, issue_valid); end
    @(negedge clk);
    total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd81) begin bad++; $display("FAIL limit_regrant got v=%b tag=%0d exp v=1 tag=81", issue_valid, issue_tag); end
    @(negedge clk);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL limit_refull got=%b exp=0", issue_valid); end
    req = 4'b0000;
    for (int t = 2; t <= 18; t++) begin
      if (t <= 17) begin retire_valid = 1'b1; retire_tag = 6'(t); end
      else retire_valid = 1'b0;
      @(negedge clk);
      if (t <= 17) begin total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL drain_rsp t=%0d got=%b exp=0001", t, rsp_valid); end end
    end
  endtask

  task automatic test_stall();
    req = 4'b0010;
    @(negedge clk);
    total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd82 || issue_id !== 2'd1) begin
      bad++; $display("FAIL stall_first got v=%b tag=%0d id=%0d exp v=1 tag=82 id=1", issue_valid, issue_tag, issue_id);
    end
    issue_stall = 1'b1; #1;
    total++; if (rq_increment !== 1'b0) begin bad++; $display("FAIL stall_inc0 got=%b exp=0", rq_increment); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd82 || issue_id !== 2'd1 || gnt !== 4'b0010 || rq_increment !== 1'b0) begin
        bad++; $display("FAIL stall_hold c=%0d got v=%b tag=%0d id=%0d gnt=%b inc=%b exp v=1 tag=82 id=1 gnt=0010 inc=0", c, issue_valid, issue_tag, issue_id, gnt, rq_increment);
      end
    end
    issue_stall = 1'b0; #1;
    total++; if (rq_increment !== 1'b1) begin bad++; $display("FAIL stall_release_inc got=%b exp=1", rq_increment); end
    @(negedge clk);
    total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd83 || issue_id !== 2'd1) begin
      bad++; $display("FAIL stall_next got v=%b tag=%0d id=%0d exp v=1 tag=83 id=1", issue_valid, issue_tag, issue_id);
    end
    req = 4'b0000;
    @(negedge clk);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", issue_valid); end
  endtask

  task automatic test_full_and_same_cycle();
    int cnt;
    req = 4'b0010; rq_full = 1'b1; #1;
    total++; if (rq_increment !== 1'b0) begin bad++; $display("FAIL full_inc got=%b exp=0", rq_increment); end
    @(negedge clk);
    total++; if (issue_valid !== 1'b0 || rq_increment !== 1'b0) begin bad++; $display("FAIL full_block got v=%b inc=%b exp 0,0", issue_valid, rq_increment); end
    rq_full = 1'b0; retire_valid = 1'b1; retire_tag = 6'd18;
    @(negedge clk);
    retire_valid = 1'b0;
    total++; if (rsp_valid !== 4'b0010 || issue_valid !== 1'b1 || issue_tag !== 7'd84 || issue_id !== 2'd1) begin
      bad++; $display("FAIL same_cycle got rsp=%b v=%b tag=%0d id=%0d exp rsp=0010 v=1 tag=84 id=1", rsp_valid, issue_valid, issue_tag, issue_id);
    end
    cnt = 0;
    repeat (25) begin @(negedge clk); if (issue_valid === 1'b1) cnt++; end
    req = 4'b0000;
    total++; if (cnt != 14) begin bad++; $display("FAIL same_cycle_credit got=%0d grants exp=14", cnt); end
  endtask

  task automatic test_reset_mid();
    int n, cnt;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({gnt, issue_valid, issue_tag, issue_id, rsp_valid, ready, rq_rst, rq_increment} !== {4'b0, 1'b0, 7'd0, 2'd0, 4'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midreset_vals got gnt=%b v=%b tag=%0d id=%0d rsp=%b rdy=%b rst=%b inc=%b exp 0,0,0,0,0,0,1,0", gnt, issue_valid, issue_tag, issue_id, rsp_valid, ready, rq_rst, rq_increment);
    end
    rst_n = 1'b1; n = 0;
    while (n < 200 && ready !== 1'b1) begin
      @(negedge clk); n++;
      if (n == 1) begin total++; if (rq_rst !== 1'b1) begin bad++; $display("FAIL midreset_rq_rst got=%b exp=1", rq_rst); end end
    end
    total++; if (n != 67) begin bad++; $display("FAIL midreset_ready got=%0d exp=67", n); end
    req = 4'b1111;
    @(negedge clk);
    total++; if (issue_valid !== 1'b1 || issue_tag !== 7'd0 || issue_id !== 2'd0) begin
      bad++; $display("FAIL midreset_first got v=%b tag=%0d id=%0d exp v=1 tag=0 id=0", issue_valid, issue_tag, issue_id);
    end
    req = 4'b0010; cnt = 0;
    repeat (25) begin @(negedge clk); if (issue_valid === 1'b1) cnt++; end
    req = 4'b0000;
    total++; if (cnt != 16) begin bad++; $display("FAIL midreset_credit got=%0d grants exp=16", cnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_stall();
    test_full_and_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
